rs_encode_param: RTL

RS_ENCODE_PARAM -- requirements
Module: rs_encode_param

---
 rtl/rs_encode_pkg.sv | 43 ++++
 rtl/rs_gf_const_mult.sv | 14 +
 rtl/rs_encode_param.sv | 97 +++++++++
 3 files changed

// File: rtl/rs_encode_pkg.sv
// Shared types and GF(2^8) helpers for the parameterised Reed-Solomon encoder.
package rs_encode_pkg;

  typedef enum logic {ST_DATA, ST_PARITY} enc_state_t;

  localparam int unsigned MAX_NPAR = 32;

  // g0..g(NPAR-1); the monic leading coefficient is implicit
  typedef logic [MAX_NPAR-1:0][7:0] gen_coef_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                         input logic [8:0] poly);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ poly[7:0]) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Multiplies out prod(x + alpha^i), i = 0..npar-1, one root at a time
  function automatic gen_coef_t rs_gen_poly(input int unsigned npar, input logic [8:0] poly);
    logic [MAX_NPAR:0][7:0] t;
    logic [7:0]             root;
    gen_coef_t              g;
    t    = '0;
    t[0] = 8'h01;
    root = 8'h01;
    for (int unsigned i = 0; i < npar; i++) begin
      for (int unsigned j = i + 1; j > 0; j--)
        t[j] = t[j-1] ^ gf_mul(t[j], root, poly);
      t[0] = gf_mul(t[0], root, poly);
      root = gf_mul(root, 8'h02, poly);
    end
    g = '0;
    for (int unsigned i = 0; i < npar; i++) g[i] = t[i];
    return g;
  endfunction

endpackage

// File: rtl/rs_gf_const_mult.sv
// GF(2^8) multiply of an 8-bit symbol by an elaboration-time constant.
module rs_gf_const_mult
  import rs_encode_pkg::*;
#(
  parameter logic [7:0] COEF      = 8'h01,
  parameter logic [8:0] PRIM_POLY = 9'h11D
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb dout = gf_mul(din, COEF, PRIM_POLY);

endmodule

// File: rtl/rs_encode_param.sv
// Systematic RS encoder: message symbols pass straight through, then NPAR parity symbols follow.
module rs_encode_param
  import rs_encode_pkg::*;
#(
  parameter int unsigned NPAR      = 16,
  parameter int unsigned K         = 239,
  parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src_encoder_data_val,
  input  logic [7:0] src_encoder_data,
  input  logic       src_encoder_last,
  output logic       encoder_src_rdy,
  output logic       encoder_dst_data_val,
  output logic [7:0] encoder_dst_data,
  output logic       encoder_dst_last,
  input  logic       dst_encoder_rdy,
  output logic       encoder_busy
);

  localparam gen_coef_t GEN = rs_gen_poly(NPAR, PRIM_POLY);

  enc_state_t                state, state_nxt;
  logic [NPAR-1:0][7:0]      par;
  logic [7:0]                prod [NPAR];
  logic [7:0]                fb;
  logic [7:0]                sym_cnt;
  logic [5:0]                par_cnt;
  logic                      src_acc, dst_acc, msg_end, par_end;

  always_comb fb = src_encoder_data ^ par[NPAR-1];

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    rs_gf_const_mult #(
      .COEF      (GEN[i]),
      .PRIM_POLY (PRIM_POLY)
    ) u_tap (
      .din  (fb),
      .dout (prod[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_DATA;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    encoder_src_rdy      = dst_encoder_rdy;
    encoder_dst_data_val = src_encoder_data_val;
    encoder_dst_data     = src_encoder_data;
    encoder_dst_last     = 1'b0;
    encoder_busy         = 1'b0;
    src_acc              = 1'b0;
    dst_acc              = 1'b0;
    msg_end              = 1'b0;
    par_end              = 1'b0;
    case (state)
      ST_DATA: begin
        src_acc = src_encoder_data_val & dst_encoder_rdy;
        msg_end = src_acc & (src_encoder_last | (sym_cnt == 8'(K - 1)));
        if (msg_end) state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        encoder_src_rdy      = 1'b0;
        encoder_busy         = 1'b1;
        encoder_dst_data_val = 1'b1;
        encoder_dst_data     = par[NPAR-1];
        encoder_dst_last     = (par_cnt == 6'(NPAR - 1));
        dst_acc              = dst_encoder_rdy;
        par_end              = dst_acc & encoder_dst_last;
        if (par_end) state_nxt = ST_DATA;
      end
      default: state_nxt = ST_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par     <= '0;
      sym_cnt <= '0;
      par_cnt <= '0;
    end else if (src_acc) begin
      par[0] <= prod[0];
      for (int unsigned i = 1; i < NPAR; i++) par[i] <= par[i-1] ^ prod[i];
      sym_cnt <= msg_end ? '0 : sym_cnt + 8'd1;
    end else if (dst_acc) begin
      // Parity leaves from the top; zero fill keeps the LFSR clean for the next message
      if (par_end) par <= '0;
      else         par <= {par[NPAR-2:0], 8'h00};
      par_cnt <= par_end ? '0 : par_cnt + 6'd1;
    end
  end

endmodule
